// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for the EX-stage radix-2 restoring divider.
// It computes one quotient bit per cycle and holds the pipeline while busy.
// When done it presents {remainder (HI), quotient (LO)} to the HI/LO write path.
module div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    // dvd_reg starts as the dividend magnitude.
    // Quotient bits shift in at the bottom, so after WIDTH steps it holds the quotient.
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             dvd_neg_reg;
    logic             quot_neg_reg;

    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] op1_mag;
    logic [WIDTH-1:0] op2_mag;
    logic [WIDTH:0]   rem_shift;
    logic             step_ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;
    logic             iter_done;

    // Operands are only negative for DIV.
    // The magnitude of the most negative value wraps to itself, which is what MIN / -1 relies on.
    assign op1_neg = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_i & opdata2_i[WIDTH-1];
    assign op1_mag = op1_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign op2_mag = op2_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    // One restoring step: bring in the next dividend bit, then try to subtract the divisor.
    // The remainder is always below the divisor, so the kept value fits in WIDTH bits.
    assign rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
    assign step_ge   = (rem_shift >= {1'b0, dvs_reg});
    assign rem_step  = step_ge ? WIDTH'(rem_shift - {1'b0, dvs_reg}) : rem_shift[WIDTH-1:0];

    // Sign fix-up: the quotient follows sign(a) ^ sign(b); the remainder follows sign(a).
    assign quot_final = quot_neg_reg ? (~dvd_reg + WIDTH'(1)) : dvd_reg;
    assign rem_final  = dvd_neg_reg  ? (~rem_reg + WIDTH'(1)) : rem_reg;

    assign iter_done = (cnt_reg == LAST_CNT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_FREE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FREE: begin
                if (start_i && !annul_i) begin
                    state_next = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                state_next = ST_END;
            end
            ST_ON: begin
                if (annul_i) begin
                    state_next = ST_FREE;
                end else if (iter_done) begin
                    state_next = ST_END;
                end
            end
            ST_END: begin
                if (annul_i || !start_i) begin
                    state_next = ST_FREE;
                end
            end
            default: state_next = ST_FREE;
        endcase
    end

    // Datapath: latch operands, iterate, and register the signed result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg      <= '0;
            dvd_reg      <= '0;
            dvs_reg      <= '0;
            rem_reg      <= '0;
            dvd_neg_reg  <= 1'b0;
            quot_neg_reg <= 1'b0;
            result_o     <= '0;
            ready_o      <= 1'b0;
        end else begin
            case (state_reg)
                ST_FREE: begin
                    if (start_i && !annul_i && (opdata2_i != '0)) begin
                        dvd_reg      <= op1_mag;
                        dvs_reg      <= op2_mag;
                        rem_reg      <= '0;
                        cnt_reg      <= '0;
                        dvd_neg_reg  <= op1_neg;
                        quot_neg_reg <= op1_neg ^ op2_neg;
                    end
                end
                ST_BYZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                ST_ON: begin
                    if (!annul_i) begin
                        if (!iter_done) begin
                            rem_reg <= rem_step;
                            dvd_reg <= {dvd_reg[WIDTH-2:0], step_ge};
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end else begin
                            result_o <= {rem_final, quot_final};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    if (annul_i || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Stall request: EX is waiting on a result that is not ready yet.
    // It is forced low while reset is asserted.
    always_comb begin
        stallreq_o = rst & start_i & ~ready_o & ~annul_i;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer for the EX-stage iterative divider.
- Accepts a DIV/DIVU request from the execute stage and runs a radix-2 restoring division over WIDTH cycles.
- Holds the pipeline via stallreq_o while busy.
- Presents {remainder, quotient} for the HI/LO write path when done.
- Supports annulment when the request is squashed by a flush/branch.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
start_i  input  1  divide request; held high by EX until ready_o is seen.
signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
opdata1_i  input  WIDTH  dividend; sampled when leaving FREE.
opdata2_i  input  WIDTH  divisor; sampled when leaving FREE.
annul_i  input  1  abort the current operation.
result_o  output  2*WIDTH  {remainder (HI), quotient (LO)}.
ready_o  output  1  result valid.
stallreq_o  output  1  pipeline stall request.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor/partial-remainder registers cleared.
  - Reset mid-operation discards all progress.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON. Latch operands, converted to magnitudes if signed_i=1 and the operand MSB=1. Latch sign flags, cnt<=0.
  - start_i=1 and annul_i=1 -> stay in FREE; the request is dropped.
- BYZERO: next cycle -> END with result 0.
- ON:
  - annul_i=1 -> FREE; result_o and ready_o stay 0.
  - cnt<WIDTH: one restoring step per cycle (shift partial remainder left, bring in next dividend bit, subtract divisor, keep if non-negative, shift in quotient bit); cnt++.
  - cnt==WIDTH -> END. Apply signs:
    - quotient negated when dividend sign != divisor sign;
    - remainder negated when dividend is negative.
  - Result is registered into result_o and ready_o<=1.
- END:
  - result_o holds and ready_o=1 while start_i=1.
  - start_i=0 -> FREE; result_o<=0, ready_o<=0.
  - annul_i=1 -> FREE; result_o<=0, ready_o<=0.
- stallreq_o is combinational: start_i & ~ready_o & ~annul_i. It is 0 in reset.
- Latency:
  - start_i first high in cycle N (state FREE) -> ready_o first high in cycle N+WIDTH+2 (34 for WIDTH=32).
  - Divide by zero: ready_o high in cycle N+2.
- Arithmetic rules:
  - Divide by zero yields result_o=0; no exception is raised.
  - Signed MIN / -1 yields quotient 0x80000000 and remainder 0 (wraps, no trap).
  - Operand changes after leaving FREE are ignored.
- Back-to-back: a new division needs start_i low for at least one cycle (END->FREE) before being accepted.

Test Plan:
- DIVU 100/7, start held -> stallreq_o=1 for 34 cycles; ready_o in cycle N+34; result_o={0x00000002, 0x0000000E}; stallreq_o=0 the same cycle.
- DIV -7/2 (0xFFFFFFF9/0x00000002) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. DIVU 0xFFFFFFFF/0x10 -> {0x0000000F, 0x0FFFFFFF}.
- Divide by zero, 5/0 -> BYZERO then END; ready_o in cycle N+2; result_o=0.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Start 100/7; assert annul_i at iteration 10 -> FREE next cycle; ready_o never rises. A fresh 9/3 afterward gives {0, 3} with full latency.
- Drive rst=0 asynchronously mid-ON -> all outputs 0 immediately. Drop start_i in END -> FREE next cycle and ready_o=0.
